// File: rtl/ballot_pkg.sv
// ballot_capture shared types: FSM state encoding, party codes, helpers.
// Optional lockout feature is selected with the BALLOT_LOCKOUT_EN macro.
package ballot_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      VALID    = 2'd1,
      WAIT_REL = 2'd2,
      LOCKOUT  = 2'd3
   } state_t;

   localparam logic [2:0] PARTY1 = 3'b001;
   localparam logic [2:0] PARTY2 = 3'b010;
   localparam logic [2:0] PARTY3 = 3'b100;

   // Exactly one bit set among the three party switches.
   function automatic logic is_onehot3(input logic [2:0] v);
      return (v != 3'b000) && ((v & (v - 3'd1)) == 3'b000);
   endfunction

endpackage

// File: rtl/ballot_capture_pb_debounce.sv
// pb_debounce: 2-flop synchronisers for PB and switches, PB debounce,
// and press/release event strobes derived from the debounced state.
module pb_debounce
   import ballot_pkg::*;
#(
   parameter int DB_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_pb,
   input  logic [2:0] i_sw,
   output logic [2:0] o_sw_sync,
   output logic       o_press_evt,
   output logic       o_release_evt
);

   localparam int DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   logic            r_pb_s1;
   logic            r_pb_s2;
   logic [2:0]      r_sw_s1;
   logic [2:0]      r_sw_s2;
   logic            r_pb_state;
   logic [DB_W-1:0] r_cnt;
   logic            r_press;
   logic            r_release;
   logic            w_differs;
   logic            w_toggle;

   assign w_differs = (r_pb_s2 != r_pb_state);
   assign w_toggle  = w_differs && (r_cnt == DB_LAST);

   // Two-stage synchronisers for the asynchronous button and switches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pb_s1 <= 1'b0;
         r_pb_s2 <= 1'b0;
         r_sw_s1 <= 3'b000;
         r_sw_s2 <= 3'b000;
      end else begin
         r_pb_s1 <= i_pb;
         r_pb_s2 <= r_pb_s1;
         r_sw_s1 <= i_sw;
         r_sw_s2 <= r_sw_s1;
      end
   end

   // Debounced state flips only after DB_CYCLES consecutive differing cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pb_state <= 1'b0;
         r_cnt      <= '0;
         r_press    <= 1'b0;
         r_release  <= 1'b0;
      end else begin
         r_press   <= w_toggle && !r_pb_state;
         r_release <= w_toggle && r_pb_state;
         if (!w_differs) begin
            r_cnt <= '0;
         end else if (w_toggle) begin
            r_pb_state <= ~r_pb_state;
            r_cnt      <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_sw_sync     = r_sw_s2;
   assign o_press_evt   = r_press;
   assign o_release_evt = r_release;

endmodule

// File: rtl/ballot_capture.sv
// ballot_capture: classifies debounced presses and hands valid votes
// downstream once on valid/ready. Macro: BALLOT_LOCKOUT_EN (post-ballot dead time).
module ballot_capture
   import ballot_pkg::*;
#(
   parameter int DB_CYCLES      = 50000,
   parameter int LOCKOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       PB,
   input  logic [2:0] voter_switch,
   input  logic       voting_en,
   output logic       vote_valid,
   output logic [2:0] vote_party,
   input  logic       vote_ready,
   output logic       invalid_pulse,
   output logic       busy
);

`ifdef BALLOT_LOCKOUT_EN
   localparam int LK_W = (LOCKOUT_CYCLES > 2) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCKOUT_CYCLES - 1);
   logic [LK_W-1:0] r_lk_cnt;
`endif

   state_t     r_state;
   logic       r_valid;
   logic [2:0] r_party;
   logic       r_invalid;
   logic       r_busy;
   logic       r_rel_seen;
   logic [2:0] w_sw;
   logic       w_press;
   logic       w_release;

   pb_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_db (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_pb          (PB),
      .i_sw          (voter_switch),
      .o_sw_sync     (w_sw),
      .o_press_evt   (w_press),
      .o_release_evt (w_release)
   );

   // Ballot FSM with registered handshake, strobe and busy outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_valid    <= 1'b0;
         r_party    <= 3'b000;
         r_invalid  <= 1'b0;
         r_busy     <= 1'b0;
         r_rel_seen <= 1'b0;
`ifdef BALLOT_LOCKOUT_EN
         r_lk_cnt   <= '0;
`endif
      end else begin
         r_invalid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_press && voting_en) begin
                  r_busy     <= 1'b1;
                  r_rel_seen <= 1'b0;
                  unique case (1'b1)
                     is_onehot3(w_sw): begin
                        r_party <= w_sw;
                        r_valid <= 1'b1;
                        r_state <= VALID;
                     end
                     (w_sw != 3'b000) && !is_onehot3(w_sw): begin
                        r_invalid <= 1'b1;
                        r_state   <= WAIT_REL;
                     end
                     default: begin
                        r_state <= WAIT_REL;
                     end
                  endcase
               end
            end
            VALID: begin
               if (w_release) begin
                  r_rel_seen <= 1'b1;
               end
               if (vote_ready) begin
                  r_valid <= 1'b0;
                  r_state <= WAIT_REL;
               end
            end
            WAIT_REL: begin
               if (w_release || r_rel_seen) begin
                  r_rel_seen <= 1'b0;
`ifdef BALLOT_LOCKOUT_EN
                  r_lk_cnt <= '0;
                  r_state  <= LOCKOUT;
`else
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
`endif
               end
            end
`ifdef BALLOT_LOCKOUT_EN
            LOCKOUT: begin
               if (r_lk_cnt == LK_LAST) begin
                  r_lk_cnt <= '0;
                  r_busy   <= 1'b0;
                  r_state  <= IDLE;
               end else begin
                  r_lk_cnt <= r_lk_cnt + 1'b1;
               end
            end
`endif
            default: begin
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign vote_valid    = r_valid;
   assign vote_party    = r_party;
   assign invalid_pulse = r_invalid;
   assign busy          = r_busy;

endmodule

// File: tb/tb_ballot_capture.sv
// Directed self-checking bench for ballot_capture (DB_CYCLES=4, LOCKOUT_CYCLES=3).
// Expected timings are hand-derived: PB rise to vote_valid is 7 cycles.
module tb_ballot_capture;
   import ballot_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       PB;
   logic [2:0] voter_switch;
   logic       voting_en;
   logic       vote_valid;
   logic [2:0] vote_party;
   logic       vote_ready;
   logic       invalid_pulse;
   logic       busy;

   int n_chk;
   int n_err;
   int n_xfer;
   int n_inv;

   ballot_capture #(
      .DB_CYCLES      (4),
      .LOCKOUT_CYCLES (3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .PB            (PB),
      .voter_switch  (voter_switch),
      .voting_en     (voting_en),
      .vote_valid    (vote_valid),
      .vote_party    (vote_party),
      .vote_ready    (vote_ready),
      .invalid_pulse (invalid_pulse),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transfers and invalid strobes counted mid-cycle, where inputs are stable.
   always @(negedge clk) begin
      if (rst_n && vote_valid && vote_ready) n_xfer++;
      if (rst_n && invalid_pulse) n_inv++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic release_pb(input string tag);
      int k;
      PB = 1'b0;
      tick(8);
      k = 0;
      while (busy && k < 40) begin
         tick(1);
         k++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   int x0;
   int i0;
   logic stable;

   initial begin
      n_chk = 0; n_err = 0; n_xfer = 0; n_inv = 0;
      rst_n = 1'b0; PB = 1'b0; voter_switch = 3'b000;
      voting_en = 1'b0; vote_ready = 1'b0;
      tick(3);
      chk("rst_valid", 32'(vote_valid), 32'd0);
      chk("rst_party", 32'(vote_party), 32'd0);
      chk("rst_inv", 32'(invalid_pulse), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Clean press, party 2, ready held high.
      voting_en = 1'b1; vote_ready = 1'b1; voter_switch = PARTY2;
      PB = 1'b1;
      tick(6);
      chk("clean_early", 32'(vote_valid), 32'd0);
      tick(1);
      chk("clean_valid", 32'(vote_valid), 32'd1);
      chk("clean_party", 32'(vote_party), 32'(PARTY2));
      tick(1);
      chk("clean_drop", 32'(vote_valid), 32'd0);
      chk("clean_busy", 32'(busy), 32'd1);
      tick(4);
      chk("clean_xfer", 32'(n_xfer), 32'd1);
      release_pb("clean_idle");

      // Bounce 1,0,1,0 then held high from the 5th cycle.
      x0 = n_xfer;
      voter_switch = PARTY1;
      PB = 1'b1; tick(1);
      PB = 1'b0; tick(1);
      PB = 1'b1; tick(1);
      PB = 1'b0; tick(1);
      PB = 1'b1;
      tick(6);
      chk("bounce_early", 32'(vote_valid), 32'd0);
      tick(1);
      chk("bounce_valid", 32'(vote_valid), 32'd1);
      chk("bounce_party", 32'(vote_party), 32'(PARTY1));
      tick(10);
      chk("bounce_count", 32'(n_xfer - x0), 32'd1);
      release_pb("bounce_idle");

      // Two switches set: invalid strobe, no vote.
      x0 = n_xfer; i0 = n_inv;
      voter_switch = 3'b011;
      PB = 1'b1;
      tick(7);
      chk("inv_pulse", 32'(invalid_pulse), 32'd1);
      chk("inv_busy", 32'(busy), 32'd1);
      tick(1);
      chk("inv_width", 32'(invalid_pulse), 32'd0);
      tick(5);
      chk("inv_novote", 32'(n_xfer - x0), 32'd0);
      chk("inv_count", 32'(n_inv - i0), 32'd1);
      release_pb("inv_idle");

      // Backpressure: ready low 10 cycles, switch change and enable drop ignored.
      x0 = n_xfer;
      vote_ready = 1'b0; voter_switch = PARTY3;
      PB = 1'b1;
      tick(7);
      chk("bp_valid", 32'(vote_valid), 32'd1);
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c == 2) voter_switch = PARTY1;
         if (c == 5) voting_en = 1'b0;
         tick(1);
         if (!vote_valid || vote_party != PARTY3) stable = 1'b0;
      end
      chk("bp_hold", 32'(stable), 32'd1);
      chk("bp_party", 32'(vote_party), 32'(PARTY3));
      chk("bp_noxfer", 32'(n_xfer - x0), 32'd0);
      vote_ready = 1'b1;
      tick(1);
      chk("bp_drop", 32'(vote_valid), 32'd0);
      chk("bp_xfer", 32'(n_xfer - x0), 32'd1);
      release_pb("bp_idle");

      // Button held 50 cycles: a single vote.
      x0 = n_xfer;
      voting_en = 1'b1; voter_switch = PARTY1;
      PB = 1'b1;
      tick(50);
      chk("held_once", 32'(n_xfer - x0), 32'd1);
      chk("held_busy", 32'(busy), 32'd1);
      release_pb("held_idle");

      // Session disabled: a press does nothing.
      x0 = n_xfer; i0 = n_inv;
      voting_en = 1'b0; voter_switch = PARTY2;
      PB = 1'b1;
      tick(12);
      chk("dis_valid", 32'(vote_valid), 32'd0);
      chk("dis_busy", 32'(busy), 32'd0);
      chk("dis_none", 32'(n_xfer - x0 + n_inv - i0), 32'd0);
      release_pb("dis_idle");

      // Asynchronous reset while a vote is held.
      voting_en = 1'b1; vote_ready = 1'b0; voter_switch = PARTY3;
      PB = 1'b1;
      tick(7);
      chk("rv_valid", 32'(vote_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rv_async", 32'(vote_valid), 32'd0);
      chk("rv_busy", 32'(busy), 32'd0);
      PB = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(3);
      chk("rv_idle", 32'(busy), 32'd0);

      // Fresh ballot after reset proves the FSM is back in IDLE.
      x0 = n_xfer;
      vote_ready = 1'b1; voter_switch = PARTY1;
      PB = 1'b1;
      tick(6);
      chk("post_early", 32'(vote_valid), 32'd0);
      tick(1);
      chk("post_valid", 32'(vote_valid), 32'd1);
      chk("post_party", 32'(vote_party), 32'(PARTY1));
      tick(2);
      chk("post_xfer", 32'(n_xfer - x0), 32'd1);
      release_pb("post_idle");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ballot_capture.md
# ballot_capture

Front-end conditioning stage of the voting machine, placed directly upstream of the per-party vote counters. It synchronises the raw push button and voter switches, debounces the button, and classifies each debounced press as a valid one-hot vote, an invalid vote, or no vote. A valid vote is presented once on a valid/ready handshake, so one physical press increments a counter exactly once.

## Interface
Parameters:
- DB_CYCLES, 50000: consecutive stable synchronised cycles required before the debounced button changes state; minimum 2.
- LOCKOUT_CYCLES, 100000: dead time after each completed ballot (only with BALLOT_LOCKOUT_EN); minimum 1.

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- PB  input  1  raw push button, asynchronous, active high.
- voter_switch  input  3  raw party switches, asynchronous; bit0 = party1, bit1 = party2, bit2 = party3.
- voting_en  input  1  session enable, synchronous to clk.
- vote_valid  output  1  a vote is being presented.
- vote_party  output  3  one-hot party; meaningful only while vote_valid = 1.
- vote_ready  input  1  the downstream counter accepts the vote.
- invalid_pulse  output  1  one-cycle strobe for a press with more than one switch set.
- busy  output  1  high in every state except IDLE.

## Operation
- PB and voter_switch each pass through a 2-flop synchroniser.
- Debounce: pb_state resets to 0, and the counter resets to 0.
  - When the synchronised PB equals pb_state, the counter clears.
  - Otherwise the counter increments. When it is at DB_CYCLES-1 and PB still differs, pb_state toggles and the counter clears.
- press_evt is a 1-cycle pulse on the 0→1 transition of pb_state. release_evt is the 1→0 transition.
- FSM states: IDLE, VALID, WAIT_REL, LOCKOUT.
  - IDLE, on press_evt with voting_en = 1, classifies the synchronised switches:
    - One-hot value: latch it into vote_party, then go to VALID.
    - Two or more bits set: pulse invalid_pulse, then go to WAIT_REL.
    - 000: go to WAIT_REL with no strobe.
  - IDLE, on press_evt with voting_en = 0: ignore the press and stay in IDLE.
  - VALID: hold vote_valid = 1 and keep vote_party stable until vote_ready = 1. That cycle is the transfer; then go to WAIT_REL.
    - If voting_en falls while in VALID, the held vote is still delivered.
  - WAIT_REL: on release_evt, go to LOCKOUT if the macro is defined, otherwise to IDLE. A release already seen while in VALID counts, and the FSM leaves WAIT_REL on the next cycle.
  - LOCKOUT: run a counter from 0 to LOCKOUT_CYCLES-1, then go to IDLE. Presses during LOCKOUT are discarded.
- Reset values: vote_valid = 0, vote_party = 000, invalid_pulse = 0, busy = 0, FSM = IDLE, pb_state = 0, all counters and synchronisers = 0.
- An asynchronous reset in any state aborts the operation immediately. An undelivered vote is dropped.

## Timing
- A PB edge to the pb_state change takes 2 synchroniser cycles plus DB_CYCLES cycles, provided PB is stable throughout. Any bounce restarts the count.
- press_evt to vote_valid (or invalid_pulse) is 1 cycle, because the outputs are registered.
- Handshake rules:
  - A transfer occurs on a rising edge where vote_valid and vote_ready are both 1.
  - vote_valid drops in the following cycle.
  - vote_valid never deasserts without a transfer.
  - vote_ready may be held high permanently; the minimum vote_valid width is then 1 cycle.
- The switches are sampled in the single press_evt cycle. Later switch changes do not affect a latched vote.
- At most one vote is produced per press-release cycle. A held button never produces a second vote.

## Configuration
- BALLOT_LOCKOUT_EN defined: the LOCKOUT state and its counter are compiled in, and after WAIT_REL the FSM spends LOCKOUT_CYCLES cycles in LOCKOUT with busy = 1.
- BALLOT_LOCKOUT_EN undefined: no LOCKOUT state or counter. WAIT_REL returns to IDLE on the cycle after release_evt.

## Structure
- Package ballot_pkg holds:
  - the FSM state enum;
  - the party constants PARTY1 = 3'b001, PARTY2 = 3'b010, PARTY3 = 3'b100;
  - the function is_onehot3.
- Sub-module pb_debounce contains the synchroniser, debounce counter and pb_state, and exposes the outputs press_evt and release_evt. The FSM and handshake stay in ballot_capture.
- Counter widths are $clog2 of the respective parameters.

## Test plan
All scenarios use DB_CYCLES = 4 and LOCKOUT_CYCLES = 3.
- Clean press with voter_switch = 010, voting_en = 1, vote_ready = 1:
  - vote_valid is high for exactly 1 cycle with vote_party = 010, 7 cycles after the PB rise (2 sync + 4 debounce + 1 register).
  - busy returns to 0 after release.
- PB bounce (1,0,1,0 on consecutive cycles, then held high): exactly one vote, and pb_state rises only after 4 stable cycles.
- voter_switch = 011 on press: invalid_pulse is high for 1 cycle, vote_valid never asserts, and the FSM passes through WAIT_REL to IDLE.
- vote_ready held low for 10 cycles:
  - vote_valid and vote_party = 100 are held stable;
  - dropping voting_en mid-wait does not cancel the vote;
  - the transfer occurs when vote_ready rises.
- Button held for 50 cycles, and a second press during LOCKOUT (with the macro): only one vote is produced. With voting_en = 0, a press yields no outputs.
- rst_n asserted while in VALID: vote_valid is 0 immediately (asynchronously), and the state is IDLE after release of reset.
